hwlp_iv_gen: RTL and testbench

- Hardware-loop induction-variable generator for one hardware-loop register-file entry. Mage instantiates one per entry.
- Walks a nested loop of up to N_LP levels and presents the current IV vector plus a valid flag each cycle.
- Its outputs form one row of the hwlp register-file/valid bundle consumed by accumulation control and the AGEs.
- Level 0 is the innermost loop.

---
 rtl/hwlp_iv_gen.sv | 99 +++++++++
 tb/tb_hwlp_iv_gen.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/hwlp_iv_gen.sv
// rtl/hwlp_iv_gen.sv - hardware-loop induction-variable generator for one hwlp register-file entry
// Walks up to N_LP nested loop levels as an odometer, level 0 innermost.
module hwlp_iv_gen #(
  parameter int N_LP       = 4,
  parameter int NBIT_LP_IV = 8,
  parameter int LOG2_N_LP  = $clog2(N_LP)
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]   reg_lp_start_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]   reg_lp_end_i,
  input  logic [N_LP*NBIT_LP_IV-1:0]   reg_lp_stride_i,
  input  logic [LOG2_N_LP-1:0]         reg_n_lp_i,
  input  logic                         start_i,
  input  logic                         en_i,
  input  logic                         flush_i,
  output logic [N_LP*NBIT_LP_IV-1:0]   hwlp_o,
  output logic                         hwlp_valid_o,
  output logic                         last_o,
  output logic                         done_o
);

  localparam int W = NBIT_LP_IV;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]            state_q;
  logic [N_LP*W-1:0]     start_q, end_q, stride_q, iv_q;
  logic [N_LP*W-1:0]     iv_nxt, iv_launch;
  logic [LOG2_N_LP-1:0]  n_lp_q;
  logic [N_LP-1:0]       at_end, active_q;
  logic                  carry;
  logic                  done_q;

  // Odometer: a level steps only while every inner active level sits at its end.
  always_comb begin
    iv_nxt    = iv_q;
    iv_launch = '0;
    at_end    = '0;
    active_q  = '0;
    carry     = 1'b1;
    for (int k = 0; k < N_LP; k++) begin
      active_q[k] = (LOG2_N_LP'(k) <= n_lp_q);
      at_end[k]   = (iv_q[k*W +: W] == end_q[k*W +: W]);
      if (LOG2_N_LP'(k) <= reg_n_lp_i)
        iv_launch[k*W +: W] = reg_lp_start_i[k*W +: W];
      if (carry && active_q[k])
        iv_nxt[k*W +: W] = at_end[k] ? start_q[k*W +: W]
                                     : iv_q[k*W +: W] + stride_q[k*W +: W];
      carry = carry & active_q[k] & at_end[k];
    end
  end

  assign last_o       = (state_q == RUN) && (&(at_end | ~active_q));
  assign hwlp_valid_o = (state_q == RUN);
  assign hwlp_o       = iv_q;
  assign done_o       = done_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= IDLE;
      start_q  <= '0;
      end_q    <= '0;
      stride_q <= '0;
      n_lp_q   <= '0;
      iv_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i && !flush_i) begin
            start_q  <= reg_lp_start_i;
            end_q    <= reg_lp_end_i;
            stride_q <= reg_lp_stride_i;
            n_lp_q   <= reg_n_lp_i;
            iv_q     <= iv_launch;
            state_q  <= RUN;
          end
        end
        default: begin
          if (flush_i) begin
            iv_q    <= '0;
            state_q <= IDLE;
          end else if (en_i) begin
            // Final iteration keeps its IVs visible after completion.
            if (last_o) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end else begin
              iv_q <= iv_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hwlp_iv_gen.sv
// tb/tb_hwlp_iv_gen.sv - self-checking bench for hwlp_iv_gen
module tb_hwlp_iv_gen;
  localparam int N_LP = 4;
  localparam int W    = 8;
  localparam int LG   = 2;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [N_LP*W-1:0] reg_lp_start_i, reg_lp_end_i, reg_lp_stride_i;
  logic [LG-1:0]     reg_n_lp_i;
  logic              start_i, en_i, flush_i;
  logic [N_LP*W-1:0] hwlp_o;
  logic              hwlp_valid_o, last_o, done_o;

  hwlp_iv_gen #(.N_LP(N_LP), .NBIT_LP_IV(W), .LOG2_N_LP(LG)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .reg_lp_start_i(reg_lp_start_i), .reg_lp_end_i(reg_lp_end_i),
    .reg_lp_stride_i(reg_lp_stride_i), .reg_n_lp_i(reg_n_lp_i),
    .start_i(start_i), .en_i(en_i), .flush_i(flush_i),
    .hwlp_o(hwlp_o), .hwlp_valid_o(hwlp_valid_o), .last_o(last_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] cs[N_LP], ce[N_LP], csd[N_LP];
  int           cn;
  logic [31:0]  exp_q[$];
  logic [W-1:0] lv[N_LP][256];
  int           ln[N_LP];

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_cfg();
    for (int k = 0; k < N_LP; k++) begin
      reg_lp_start_i[k*W +: W]  = cs[k];
      reg_lp_end_i[k*W +: W]    = ce[k];
      reg_lp_stride_i[k*W +: W] = csd[k];
    end
    reg_n_lp_i = LG'(cn);
  endtask

  task automatic launch();
    drive_cfg();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  // Reference: per-level value lists, expanded as a Cartesian product with level 0 fastest.
  task automatic build_exp();
    int total, r;
    logic [W-1:0] v;
    logic [31:0] row;
    total = 1;
    for (int k = 0; k <= cn; k++) begin
      v = cs[k];
      ln[k] = 0;
      for (int n = 0; n < 256; n++) begin
        lv[k][ln[k]] = v;
        ln[k]++;
        if (v == ce[k]) break;
        v = v + csd[k];
      end
      total *= ln[k];
    end
    exp_q.delete();
    for (int idx = 0; idx < total; idx++) begin
      r = idx;
      row = '0;
      for (int k = 0; k <= cn; k++) begin
        row[k*W +: W] = lv[k][r % ln[k]];
        r = r / ln[k];
      end
      exp_q.push_back(row);
    end
  endtask

  // Checks from the first live iteration through the done cycle; returns at the done cycle.
  task automatic walk(input bit rand_en, input bit noise);
    int idx, cyc, total;
    build_exp();
    total = exp_q.size();
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < 4000) begin
      chk("valid", 32'(hwlp_valid_o), 32'd1);
      chk("iv", hwlp_o, exp_q[idx]);
      chk("last", 32'(last_o), 32'(idx == total - 1));
      chk("done_run", 32'(done_o), 32'd0);
      en_i = rand_en ? ($urandom % 4 != 0) : 1'b1;
      if (noise) begin
        start_i = 1'($urandom);
        reg_lp_start_i = $urandom;
        reg_lp_end_i = $urandom;
        reg_lp_stride_i = $urandom;
        reg_n_lp_i = LG'($urandom);
      end
      step();
      start_i = 1'b0;
      if (en_i) idx++;
      cyc++;
    end
    en_i = 1'b0;
    if (idx < total) chk("timeout", 32'(idx), 32'(total));
    chk("done_pulse", 32'(done_o), 32'd1);
    chk("valid_done", 32'(hwlp_valid_o), 32'd0);
    chk("iv_final", hwlp_o, exp_q[total-1]);
    chk("last_done", 32'(last_o), 32'd0);
  endtask

  task automatic cfg_clear();
    for (int k = 0; k < N_LP; k++) begin
      cs[k] = '0; ce[k] = '0; csd[k] = '0;
    end
    cn = 0;
  endtask

  task automatic cfg_rand();
    int c;
    cn = $urandom % N_LP;
    for (int k = 0; k < N_LP; k++) begin
      cs[k]  = W'($urandom);
      c      = $urandom_range(1, 4);
      csd[k] = (c == 1) ? W'($urandom) : W'($urandom_range(1, 255));
      ce[k]  = cs[k] + W'(csd[k] * (c - 1));
    end
  endtask

  initial begin
    rst_n_i = 1'b0;
    start_i = 1'b0; en_i = 1'b0; flush_i = 1'b0;
    reg_lp_start_i = '0; reg_lp_end_i = '0; reg_lp_stride_i = '0; reg_n_lp_i = '0;
    step(); step();
    chk("rst_iv", hwlp_o, 32'd0);
    chk("rst_valid", 32'(hwlp_valid_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    rst_n_i = 1'b1;
    step();

    // single level 0..3
    cfg_clear(); ce[0] = 8'd3; csd[0] = 8'd1;
    chk("ref_len", 32'd4, 32'd4);
    launch(); walk(1'b0, 1'b0);
    step(); chk("done_one_cycle", 32'(done_o), 32'd0);

    // two levels
    cfg_clear(); cn = 1;
    ce[0] = 8'd2; csd[0] = 8'd2;
    cs[1] = 8'd1; ce[1] = 8'd3; csd[1] = 8'd1;
    cs[2] = 8'd9; cs[3] = 8'd7;
    launch(); walk(1'b0, 1'b0);
    chk("two_level_len", 32'(exp_q.size()), 32'd6);
    step();

    // stalls
    cfg_clear(); ce[0] = 8'd3; csd[0] = 8'd1;
    launch(); walk(1'b1, 1'b0);
    step();

    // wrap-around
    cfg_clear(); cs[0] = 8'd254; ce[0] = 8'd1; csd[0] = 8'd1;
    launch(); walk(1'b0, 1'b0);
    chk("wrap_len", 32'(exp_q.size()), 32'd4);
    step();

    // flush on second RUN cycle
    cfg_clear(); ce[0] = 8'd3; csd[0] = 8'd1;
    launch();
    en_i = 1'b1; step();
    chk("flush_pre_iv", hwlp_o, 32'd1);
    flush_i = 1'b1; step(); flush_i = 1'b0; en_i = 1'b0;
    chk("flush_valid", 32'(hwlp_valid_o), 32'd0);
    chk("flush_iv", hwlp_o, 32'd0);
    chk("flush_done", 32'(done_o), 32'd0);
    step();
    chk("flush_done2", 32'(done_o), 32'd0);

    // flush in IDLE blocks start
    drive_cfg(); start_i = 1'b1; flush_i = 1'b1; step();
    start_i = 1'b0; flush_i = 1'b0;
    chk("flush_blocks_start", 32'(hwlp_valid_o), 32'd0);

    // back-to-back launch in the done cycle
    cfg_clear(); ce[0] = 8'd1; csd[0] = 8'd1;
    launch(); walk(1'b0, 1'b0);
    cfg_clear(); cs[0] = 8'd5; ce[0] = 8'd6; csd[0] = 8'd1;
    launch(); walk(1'b0, 1'b0);
    step();

    // reset mid-run
    cfg_clear(); cs[0] = 8'd10; ce[0] = 8'd20; csd[0] = 8'd1;
    launch(); en_i = 1'b1; step(); en_i = 1'b0;
    #2 rst_n_i = 1'b0;
    #1;
    chk("rst_mid_iv", hwlp_o, 32'd0);
    chk("rst_mid_valid", 32'(hwlp_valid_o), 32'd0);
    chk("rst_mid_last", 32'(last_o), 32'd0);
    chk("rst_mid_done", 32'(done_o), 32'd0);
    @(negedge clk_i) rst_n_i = 1'b1;
    step();
    chk("post_rst_valid", 32'(hwlp_valid_o), 32'd0);
    chk("post_rst_done", 32'(done_o), 32'd0);
    step();
    chk("post_rst_valid2", 32'(hwlp_valid_o), 32'd0);

    // randomized runs with stalls, ignored config/start noise and occasional back-to-back
    for (int t = 0; t < 40; t++) begin
      cfg_rand();
      launch();
      walk(1'b1, 1'b1);
      if ($urandom % 3 != 0) begin
        step();
        chk("rand_done_one", 32'(done_o), 32'd0);
      end
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
